// File: rtl/msrv32_lu_seq.sv
// -----------------------------------------------------------------------------
// msrv32_lu_seq
//   Sequential load unit between the core memory stage and the data-bus master.
//   It takes one load request at a time and issues one aligned bus read, or two
//   when the access crosses a bus-word boundary. It merges the returned beats,
//   extracts the addressed bytes, sign- or zero-extends them and returns the
//   result through a valid/ready handshake.
//
// Handshakes (valid/ready):
//   A transfer happens on a rising clk_in edge where valid and ready are both 1.
//   Once valid is raised, valid and its payload stay stable until that edge.
//   The request side accepts only in IDLE. On the result side, res_valid_out
//   and the result payload hold until res_ready_in. On the bus side, a read is
//   requested while bus_req_out=1 and is taken on a cycle where bus_gnt_in=1.
//   The data returns later with bus_rvalid_in.
//
// Ports:
//   clk_in, rst_in                  clock, synchronous active-high reset
//   req_valid_in / req_ready_out    request handshake
//   addr_in, load_size_in,          byte address, size (00 B, 01 H, 10 W,
//   load_unsigned_in                11 D or W when XLEN=32), zero-extend flag
//   flush_in                        abort the current load; no result
//   bus_req_out, bus_addr_out       aligned bus read request and address
//   bus_gnt_in, bus_rvalid_in,      bus grant, read-data valid,
//   bus_rdata_in, bus_err_in        read data, error (qualified by rvalid)
//   res_valid_out / res_ready_in    result handshake
//   res_data_out, res_err_out,      extended data, bus error flag,
//   res_misalign_out                misaligned flag (MISALIGN_EN=0 only)
//   dbg_state_out                   current FSM state, for observation
// -----------------------------------------------------------------------------
module msrv32_lu_seq #(
  parameter int XLEN        = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            req_valid_in,
  output logic            req_ready_out,
  input  logic [XLEN-1:0] addr_in,
  input  logic [1:0]      load_size_in,
  input  logic            load_unsigned_in,
  input  logic            flush_in,
  output logic            bus_req_out,
  output logic [XLEN-1:0] bus_addr_out,
  input  logic            bus_gnt_in,
  input  logic            bus_rvalid_in,
  input  logic [XLEN-1:0] bus_rdata_in,
  input  logic            bus_err_in,
  output logic            res_valid_out,
  input  logic            res_ready_in,
  output logic [XLEN-1:0] res_data_out,
  output logic            res_err_out,
  output logic            res_misalign_out,
  output logic [2:0]      dbg_state_out
);

  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int CW    = OFFW + 2;  // wide enough to hold off + nbytes
  localparam logic [XLEN-1:0] ONES = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_REQ1  = 3'd3,
    S_WAIT1 = 3'd4,
    S_RESP  = 3'd5,
    S_DRAIN = 3'd6
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_addr;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic              r_cross;
  logic [XLEN-1:0]   r_beat0;
  logic [XLEN-1:0]   r_res_data;
  logic              r_res_err;
  logic              r_res_mis;

  function automatic logic [CW-1:0] f_nbytes(input logic [1:0] size);
    case (size)
      2'b00:   return CW'(1);
      2'b01:   return CW'(2);
      2'b10:   return CW'(4);
      default: return (XLEN == 64) ? CW'(8) : CW'(4);
    endcase
  endfunction

  // Crossing detection on the incoming request, before it is registered.
  logic [CW-1:0] w_in_end;
  logic          w_in_cross;
  assign w_in_end   = {2'b00, addr_in[OFFW-1:0]} + f_nbytes(load_size_in);
  assign w_in_cross = (w_in_end > CW'(BYTES));

  logic [XLEN-1:0] w_base;
  assign w_base = {r_addr[XLEN-1:OFFW], {OFFW{1'b0}}};

  // Merge: in WAIT0 the live beat is beat0 (beat1 taken as zero); in WAIT1
  // the live beat is beat1 and beat0 comes from its register.
  logic [XLEN-1:0]   w_b0, w_b1;
  logic [2*XLEN-1:0] w_pair;
  logic [XLEN-1:0]   w_lo, w_mask, w_result;
  logic              w_sign;

  assign w_b0   = (r_state == S_WAIT1) ? r_beat0 : bus_rdata_in;
  assign w_b1   = (r_state == S_WAIT1) ? bus_rdata_in : '0;
  assign w_pair = {w_b1, w_b0} >> {r_addr[OFFW-1:0], 3'b000};
  assign w_lo   = w_pair[XLEN-1:0];

  always_comb begin
    w_mask = ONES;
    w_sign = 1'b0;
    case (r_size)
      2'b00: begin w_mask = ~(ONES << 8);  w_sign = w_lo[7];  end
      2'b01: begin w_mask = ~(ONES << 16); w_sign = w_lo[15]; end
      2'b10: begin w_mask = ~(ONES << 32); w_sign = w_lo[31]; end
      default: begin w_mask = ONES; w_sign = w_lo[XLEN-1]; end
    endcase
  end

  assign w_result = (w_lo & w_mask) | ((w_sign && !r_unsigned) ? ~w_mask : '0);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_cross    <= 1'b0;
      r_beat0    <= '0;
      r_res_data <= '0;
      r_res_err  <= 1'b0;
      r_res_mis  <= 1'b0;
    end else if (flush_in) begin
      r_res_data <= '0;
      r_res_err  <= 1'b0;
      r_res_mis  <= 1'b0;
      case (r_state)
        // A read is in flight: its response must be swallowed unless it
        // arrives in this very cycle.
        S_WAIT0, S_WAIT1, S_DRAIN:
          r_state <= bus_rvalid_in ? S_IDLE : S_DRAIN;
        default: r_state <= S_IDLE;
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_in) begin
            r_addr     <= addr_in;
            r_size     <= load_size_in;
            r_unsigned <= load_unsigned_in;
            r_cross    <= w_in_cross;
            if (w_in_cross && !MISALIGN_EN) begin
              r_res_data <= '0;
              r_res_err  <= 1'b0;
              r_res_mis  <= 1'b1;
              r_state    <= S_RESP;
            end else begin
              r_state <= S_REQ0;
            end
          end
        end
        S_REQ0: if (bus_gnt_in) r_state <= S_WAIT0;
        S_WAIT0: begin
          if (bus_rvalid_in) begin
            r_beat0 <= bus_rdata_in;
            if (bus_err_in) begin
              r_res_data <= '0;
              r_res_err  <= 1'b1;
              r_state    <= S_RESP;
            end else if (r_cross) begin
              r_state <= S_REQ1;
            end else begin
              r_res_data <= w_result;
              r_state    <= S_RESP;
            end
          end
        end
        S_REQ1: if (bus_gnt_in) r_state <= S_WAIT1;
        S_WAIT1: begin
          if (bus_rvalid_in) begin
            r_res_data <= bus_err_in ? '0 : w_result;
            r_res_err  <= bus_err_in;
            r_state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (res_ready_in) begin
            r_res_data <= '0;
            r_res_err  <= 1'b0;
            r_res_mis  <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_DRAIN: if (bus_rvalid_in) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_out    = (r_state == S_IDLE);
  assign res_valid_out    = (r_state == S_RESP);
  assign res_data_out     = r_res_data;
  assign res_err_out      = r_res_err;
  assign res_misalign_out = r_res_mis;
  // Gated by flush_in so a flushed request can never be granted.
  assign bus_req_out      = ((r_state == S_REQ0) || (r_state == S_REQ1)) && !flush_in;
  assign bus_addr_out     = (r_state == S_REQ1) ? (w_base + XLEN'(BYTES)) : w_base;
  assign dbg_state_out    = r_state;

endmodule

// File: tb/tb_msrv32_lu_seq.sv
module tb_msrv32_lu_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT A: MISALIGN_EN=1 ----------------
  logic        a_req_valid, a_req_ready, a_uns, a_flush;
  logic [31:0] a_addr, a_bus_addr, a_rdata, a_res_data;
  logic [1:0]  a_size;
  logic        a_bus_req, a_gnt, a_rvalid, a_err;
  logic        a_res_valid, a_res_ready, a_res_err, a_res_mis;
  logic [2:0]  a_state;

  msrv32_lu_seq #(.XLEN(32), .MISALIGN_EN(1'b1)) u_dut_a (
    .clk_in(clk), .rst_in(rst),
    .req_valid_in(a_req_valid), .req_ready_out(a_req_ready),
    .addr_in(a_addr), .load_size_in(a_size), .load_unsigned_in(a_uns),
    .flush_in(a_flush),
    .bus_req_out(a_bus_req), .bus_addr_out(a_bus_addr),
    .bus_gnt_in(a_gnt), .bus_rvalid_in(a_rvalid), .bus_rdata_in(a_rdata),
    .bus_err_in(a_err),
    .res_valid_out(a_res_valid), .res_ready_in(a_res_ready),
    .res_data_out(a_res_data), .res_err_out(a_res_err),
    .res_misalign_out(a_res_mis), .dbg_state_out(a_state)
  );

  // ---------------- DUT B: MISALIGN_EN=0 ----------------
  logic        b_req_valid, b_req_ready, b_uns, b_flush;
  logic [31:0] b_addr, b_bus_addr, b_rdata, b_res_data;
  logic [1:0]  b_size;
  logic        b_bus_req, b_gnt, b_rvalid, b_err;
  logic        b_res_valid, b_res_ready, b_res_err, b_res_mis;
  logic [2:0]  b_state;

  msrv32_lu_seq #(.XLEN(32), .MISALIGN_EN(1'b0)) u_dut_b (
    .clk_in(clk), .rst_in(rst),
    .req_valid_in(b_req_valid), .req_ready_out(b_req_ready),
    .addr_in(b_addr), .load_size_in(b_size), .load_unsigned_in(b_uns),
    .flush_in(b_flush),
    .bus_req_out(b_bus_req), .bus_addr_out(b_bus_addr),
    .bus_gnt_in(b_gnt), .bus_rvalid_in(b_rvalid), .bus_rdata_in(b_rdata),
    .bus_err_in(b_err),
    .res_valid_out(b_res_valid), .res_ready_in(b_res_ready),
    .res_data_out(b_res_data), .res_err_out(b_res_err),
    .res_misalign_out(b_res_mis), .dbg_state_out(b_state)
  );

  // ---------------- bus monitors ----------------
  int   checks = 0;
  int   errors = 0;
  int   a_gnts = 0;
  logic b_req_seen;

  always @(posedge clk) begin
    if (a_bus_req && a_gnt) a_gnts <= a_gnts + 1;
    if (rst) b_req_seen <= 1'b0;
    else if (b_bus_req) b_req_seen <= 1'b1;
  end

  // ---------------- checker / helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one load on DUT A with grant and rvalid at the earliest cycle and
  // checks bus addresses, latency, result and grant count.
  task automatic run_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic two, input logic [31:0] b0,
                          input logic [31:0] b1, input logic [31:0] exp_addr0,
                          input logic [31:0] exp_addr1, input logic [31:0] exp_data);
    int g0;
    g0 = a_gnts;
    check({tag, "_ready"}, a_req_ready, 1'b1);
    a_req_valid = 1'b1; a_addr = addr; a_size = size; a_uns = uns;
    tick;                                 // N+1
    a_req_valid = 1'b0;
    check({tag, "_req0"}, a_bus_req, 1'b1);
    check({tag, "_addr0"}, a_bus_addr, exp_addr0);
    a_gnt = 1'b1;
    tick;                                 // N+2
    a_gnt = 1'b0;
    check({tag, "_noreq_w0"}, a_bus_req, 1'b0);
    a_rvalid = 1'b1; a_rdata = b0;
    tick;                                 // N+3
    a_rvalid = 1'b0; a_rdata = '0;
    if (two) begin
      check({tag, "_nores_early"}, a_res_valid, 1'b0);
      check({tag, "_req1"}, a_bus_req, 1'b1);
      check({tag, "_addr1"}, a_bus_addr, exp_addr1);
      a_gnt = 1'b1;
      tick;                               // N+4
      a_gnt = 1'b0;
      a_rvalid = 1'b1; a_rdata = b1;
      tick;                               // N+5
      a_rvalid = 1'b0; a_rdata = '0;
    end
    check({tag, "_valid"}, a_res_valid, 1'b1);
    check({tag, "_data"}, a_res_data, exp_data);
    check({tag, "_err"}, a_res_err, 1'b0);
    check({tag, "_gnts"}, a_gnts - g0, two ? 2 : 1);
    a_res_ready = 1'b1;
    tick;
    a_res_ready = 1'b0;
    check({tag, "_done"}, a_res_valid, 1'b0);
    check({tag, "_idle"}, a_req_ready, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    a_req_valid = 0; a_addr = 0; a_size = 0; a_uns = 0; a_flush = 0;
    a_gnt = 0; a_rvalid = 0; a_rdata = 0; a_err = 0; a_res_ready = 0;
    b_req_valid = 0; b_addr = 0; b_size = 0; b_uns = 0; b_flush = 0;
    b_gnt = 0; b_rvalid = 0; b_rdata = 0; b_err = 0; b_res_ready = 0;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;

    // reset state
    check("rst_ready", a_req_ready, 1'b1);
    check("rst_valid", a_res_valid, 1'b0);
    check("rst_busreq", a_bus_req, 1'b0);
    check("rst_data", a_res_data, 32'h0);
    check("rst_flags", {a_res_err, a_res_mis}, 2'b00);
    check("rst_b_ready", b_req_ready, 1'b1);

    // 1: LB signed / unsigned
    run_load("lb_s", 32'h1003, 2'b00, 1'b0, 1'b0, 32'h80FF1234, 32'h0, 32'h1000, 32'h0, 32'hFFFFFF80);
    run_load("lb_u", 32'h1003, 2'b00, 1'b1, 1'b0, 32'h80FF1234, 32'h0, 32'h1000, 32'h0, 32'h00000080);
    // aligned halves
    run_load("lh_s", 32'h1002, 2'b01, 1'b0, 1'b0, 32'hBEEF1234, 32'h0, 32'h1000, 32'h0, 32'hFFFFBEEF);
    run_load("lh_u", 32'h1002, 2'b01, 1'b1, 1'b0, 32'hBEEF1234, 32'h0, 32'h1000, 32'h0, 32'h0000BEEF);
    // 2: split LW
    run_load("lw_x", 32'h1006, 2'b10, 1'b0, 1'b1, 32'hAABBCCDD, 32'h11223344, 32'h1004, 32'h1008, 32'h3344AABB);
    // 3: split LH signed
    run_load("lh_x", 32'h1003, 2'b01, 1'b0, 1'b1, 32'h7F000000, 32'h00000080, 32'h1000, 32'h1004, 32'hFFFF807F);
    // split LW across top of address space, second beat wraps to 0
    run_load("lw_wrap", 32'hFFFFFFFE, 2'b10, 1'b0, 1'b1, 32'h44332211, 32'h88776655, 32'hFFFFFFFC, 32'h00000000, 32'h66554433);
    // size 11 is a word on XLEN=32
    run_load("ld_w", 32'h1008, 2'b11, 1'b0, 1'b0, 32'h87654321, 32'h0, 32'h1008, 32'h0, 32'h87654321);

    // 4: MISALIGN_EN=0 trap
    b_req_valid = 1'b1; b_addr = 32'h1002; b_size = 2'b10;
    tick;
    b_req_valid = 1'b0;
    check("mis_valid", b_res_valid, 1'b1);
    check("mis_flag", b_res_mis, 1'b1);
    check("mis_data", b_res_data, 32'h0);
    check("mis_busreq", b_bus_req, 1'b0);
    check("mis_notready", b_req_ready, 1'b0);
    b_res_ready = 1'b1;
    tick;
    b_res_ready = 1'b0;
    check("mis_done", b_res_valid, 1'b0);
    check("mis_clear", b_res_mis, 1'b0);
    // flush in RESP drops the result
    b_req_valid = 1'b1; b_addr = 32'h1003; b_size = 2'b01;
    tick;
    b_req_valid = 1'b0;
    check("mis2_valid", b_res_valid, 1'b1);
    b_flush = 1'b1;
    tick;
    b_flush = 1'b0;
    check("flush_resp_valid", b_res_valid, 1'b0);
    check("flush_resp_ready", b_req_ready, 1'b1);
    check("mis_never_bus", b_req_seen, 1'b0);

    // 5: error on beat0 of a split load, consumer stalls 3 cycles
    begin
      int g0;
      g0 = a_gnts;
      a_req_valid = 1'b1; a_addr = 32'h1006; a_size = 2'b10; a_uns = 1'b0;
      tick;
      a_req_valid = 1'b0;
      check("err_addr0", a_bus_addr, 32'h1004);
      a_gnt = 1'b1;
      tick;
      a_gnt = 1'b0;
      a_rvalid = 1'b1; a_err = 1'b1; a_rdata = 32'h12345678;
      tick;
      a_rvalid = 1'b0; a_err = 1'b0; a_rdata = '0;
      for (int i = 0; i < 3; i++) begin
        check("err_valid", a_res_valid, 1'b1);
        check("err_flag", a_res_err, 1'b1);
        check("err_data", a_res_data, 32'h0);
        check("err_notready", a_req_ready, 1'b0);
        check("err_noreq1", a_bus_req, 1'b0);
        tick;
      end
      check("err_hold_valid", a_res_valid, 1'b1);
      a_res_ready = 1'b1;
      tick;
      a_res_ready = 1'b0;
      check("err_done", a_res_valid, 1'b0);
      check("err_clear", a_res_err, 1'b0);
      check("err_gnts", a_gnts - g0, 1);
    end

    // 6: flush in WAIT0, response two cycles later is drained
    a_req_valid = 1'b1; a_addr = 32'h1000; a_size = 2'b10;
    tick;
    a_req_valid = 1'b0;
    a_gnt = 1'b1;
    tick;
    a_gnt = 1'b0;
    a_flush = 1'b1;
    tick;
    a_flush = 1'b0;
    check("drain_novalid", a_res_valid, 1'b0);
    check("drain_notready", a_req_ready, 1'b0);
    tick;
    a_rvalid = 1'b1; a_rdata = 32'h55555555;
    tick;
    a_rvalid = 1'b0; a_rdata = '0;
    check("drain_ready", a_req_ready, 1'b1);
    check("drain_novalid2", a_res_valid, 1'b0);
    run_load("after_drain", 32'h2000, 2'b10, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 32'h2000, 32'h0, 32'hDEADBEEF);

    // flush coincident with rvalid in WAIT0 goes straight to IDLE
    a_req_valid = 1'b1; a_addr = 32'h1004; a_size = 2'b00;
    tick;
    a_req_valid = 1'b0;
    a_gnt = 1'b1;
    tick;
    a_gnt = 1'b0;
    a_flush = 1'b1; a_rvalid = 1'b1; a_rdata = 32'h0000007F;
    tick;
    a_flush = 1'b0; a_rvalid = 1'b0; a_rdata = '0;
    check("flush_rv_ready", a_req_ready, 1'b1);
    check("flush_rv_novalid", a_res_valid, 1'b0);

    // flush in REQ0 drops bus_req in the same cycle
    a_req_valid = 1'b1; a_addr = 32'h1000; a_size = 2'b10;
    tick;
    a_req_valid = 1'b0;
    check("req0_up", a_bus_req, 1'b1);
    a_flush = 1'b1;
    #1;
    check("req0_flush_drop", a_bus_req, 1'b0);
    tick;
    a_flush = 1'b0;
    check("req0_flush_idle", a_req_ready, 1'b1);
    check("req0_flush_noreq", a_bus_req, 1'b0);

    // flush in IDLE blocks acceptance
    a_flush = 1'b1; a_req_valid = 1'b1; a_addr = 32'h1000; a_size = 2'b10;
    tick;
    a_flush = 1'b0; a_req_valid = 1'b0;
    check("idle_flush_block", a_req_ready, 1'b1);
    check("idle_flush_noreq", a_bus_req, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msrv32_lu_seq.md
Name: msrv32_lu_seq

Overview:
Parametrised sequential load unit, the successor to the combinational load unit. It accepts a load request from the core and issues one or two aligned bus reads; two reads are needed when the access crosses a bus-word boundary. It merges the returned beats, extracts and sign- or zero-extends the addressed bytes, and returns the result through a valid/ready handshake. It sits between the core's memory stage and the data-bus master.

Parameters:
XLEN, 32, data and address width; legal values 32 or 64; bus word is XLEN/8 bytes.
MISALIGN_EN, 1, 1 = split boundary-crossing loads into two beats; 0 = flag them as misaligned with no bus access.

Ports:
clk_in  input  1  clock; all state updates on rising edge.
rst_in  input  1  synchronous, active-high reset.
req_valid_in  input  1  load request valid.
req_ready_out  output  1  unit can accept a request.
addr_in  input  XLEN  byte address of load.
load_size_in  input  2  00 byte, 01 half, 10 word, 11 double (XLEN=64 only; treated as word when XLEN=32).
load_unsigned_in  input  1  1 = zero-extend, 0 = sign-extend.
flush_in  input  1  abort the current load; no result is produced.
bus_req_out  output  1  bus read request.
bus_addr_out  output  XLEN  bus-word-aligned read address (low log2(XLEN/8) bits are zero).
bus_gnt_in  input  1  request accepted by bus this cycle.
bus_rvalid_in  input  1  read data valid.
bus_rdata_in  input  XLEN  read data.
bus_err_in  input  1  error response; qualified by bus_rvalid_in.
res_valid_out  output  1  result valid.
res_ready_in  input  1  consumer accepts result.
res_data_out  output  XLEN  extended load data.
res_err_out  output  1  bus error occurred.
res_misalign_out  output  1  misaligned access, MISALIGN_EN=0 only.

Behaviour:
- Reset: state=IDLE. All outputs 0 except req_ready_out=1. Internal beat registers cleared. Reset mid-transaction abandons it silently; the bus side is reset on the same rst_in.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP, DRAIN.
- Request capture:
  - req_ready_out=1 only in IDLE.
  - On req_valid_in&&req_ready_out, register addr, size and unsigned flag.
  - off = addr[log2(XLEN/8)-1:0]; nbytes = 1, 2, 4 or 8.
  - cross = (off+nbytes > XLEN/8).
- IDLE transitions on accept:
  - cross && !MISALIGN_EN -> RESP with res_misalign_out=1, res_data_out=0.
  - Otherwise -> REQ0.
- REQ0: bus_req_out=1, bus_addr_out=aligned(addr). On bus_gnt_in -> WAIT0.
- WAIT0: on bus_rvalid_in, store beat0.
  - bus_err_in -> RESP with res_err_out=1, res_data_out=0; second beat is never issued.
  - Else cross -> REQ1; else -> RESP.
- REQ1: bus_req_out=1, bus_addr_out=aligned(addr)+XLEN/8, wrapping modulo 2^XLEN. On bus_gnt_in -> WAIT1.
- WAIT1: on bus_rvalid_in, store beat1 (error handled as in WAIT0) -> RESP.
- Merge and extension:
  - Form {beat1,beat0}; beat1=0 if not cross.
  - Shift right by off*8 and keep the low nbytes*8 bits.
  - Extend to XLEN: sign from the top kept bit unless unsigned.
- RESP:
  - res_valid_out=1; result outputs registered.
  - res_data_out, res_err_out and res_misalign_out hold stable until res_ready_in.
  - On res_ready_in -> IDLE; flags clear.
- Latency (grant and rvalid each arrive the earliest possible cycle, acceptance at cycle N):
  - Aligned: bus_req_out at N+1, rvalid at N+2, res_valid_out at N+3.
  - Crossing: res_valid_out at N+5.
  - Misaligned trap: res_valid_out at N+1.
- flush_in (priority below rst_in, above all else):
  - In REQ0/REQ1 -> IDLE; bus_req_out drops the same cycle it is sampled and no bus transaction is outstanding.
  - In WAIT0/WAIT1 -> DRAIN. DRAIN discards the next bus_rvalid_in, then -> IDLE.
  - In RESP -> IDLE; the result is dropped.
  - In IDLE it blocks acceptance that cycle.
- Simultaneous events: flush_in with bus_rvalid_in in WAIT0/WAIT1 treats the response as consumed -> IDLE directly.
- One load outstanding at a time; no bus pipelining.

Test Plan:
1. XLEN=32, LB signed addr 0x1003, beat0 0x80FF1234 -> bus_addr_out 0x1000, res_data_out 0xFFFFFF80 at N+3; unsigned repeat -> 0x00000080.
2. LW addr 0x1006, beat0 (0x1004) 0xAABBCCDD, beat1 (0x1008) 0x11223344 -> res_data_out 0x3344AABB; exactly two bus grants.
3. LH signed addr 0x1003, beat0 0x7F000000, beat1 0x00000080 -> res_data_out 0xFFFF807F.
4. MISALIGN_EN=0, LW addr 0x1002 -> bus_req_out never asserted, res_valid_out at N+1, res_misalign_out=1, data 0.
5. Split LW at 0x1006, bus_err_in on beat0 -> no second request, res_err_out=1, res_data_out=0; res_ready_in low 3 cycles -> outputs stable, req_ready_out=0 throughout.
6. flush_in in WAIT0, rvalid 2 cycles later -> no res_valid_out, req_ready_out=1 the cycle after rvalid; next LW addr 0x2000 data 0xDEADBEEF completes correctly.
